genius_datapath: RTL

GENIUS_DATAPATH -- requirements
Module: genius_datapath

---
 rtl/genius_pkg.sv | 23 ++
 rtl/genius_lfsr.sv | 24 ++
 rtl/genius_datapath.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius (Simon-style) memory game datapath:
// colour codes, LFSR seed/taps, result LED patterns and the colour decode.
package genius_pkg;

    typedef enum logic [1:0] {
        COL_GREEN  = 2'd0,
        COL_RED    = 2'd1,
        COL_YELLOW = 2'd2,
        COL_BLUE   = 2'd3
    } colour_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [3:0] LED_WIN  = 4'b1111;
    localparam logic [3:0] LED_LOSE = 4'b1001;

    function automatic logic [3:0] onehot(input logic [1:0] code);
        onehot = 4'b0001 << code;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; the low two bits feed new sequence colours.
module genius_lfsr
    import genius_pkg::*;
(
    input  logic        CLOCK,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {^(q_q & LFSR_TAPS), q_q[15:1]};
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) q_q <= LFSR_SEED;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/genius_datapath.sv
// Genius game datapath: sequence memory, FPGA playback, user key checking and
// status flags, sequenced by single-cycle strobes from an external controller.
module genius_datapath
    import genius_pkg::*;
#(
    parameter int SEQ_LEN        = 16,
    parameter int STEP_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                       CLOCK,
    input  logic                       reset,
    input  logic                       R1,
    input  logic                       R2,
    input  logic                       E1,
    input  logic                       E2,
    input  logic                       E3,
    input  logic                       E4,
    input  logic                       SEL,
    input  logic [3:0]                 KEY,
    output logic [3:0]                 LEDR,
    output logic [$clog2(SEQ_LEN)-1:0] ROUND,
    output logic                       end_FPGA,
    output logic                       end_User,
    output logic                       end_time,
    output logic                       win,
    output logic                       match
);

    localparam int RW = $clog2(SEQ_LEN);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] LAST_ROUND = RW'(SEQ_LEN - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] STEP_HALF  = SW'(STEP_CYCLES / 2);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   STEP_U     = 32'(STEP_CYCLES);

    logic [15:0]   lfsr_q;
    logic [1:0]    mem_q [SEQ_LEN];
    logic          mem_we;
    logic [RW-1:0] mem_addr;

    logic [RW-1:0] round_q, round_d, play_idx_q, play_idx_d, user_idx_q, user_idx_d;
    logic [SW-1:0] step_q, step_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    echo_q, echo_d, exp_key;
    logic          err_q, err_d, won_q, won_d, match_q, match_d;
    logic          end_fpga_q, end_fpga_d, end_user_q, end_user_d, end_time_q, end_time_d;

    genius_lfsr u_lfsr (
        .CLOCK (CLOCK),
        .reset (reset),
        .q     (lfsr_q)
    );

    // E4 is a pure observation phase and only two LFSR bits make colours.
    logic unused_sink;
    assign unused_sink = ^{lfsr_q[15:2], E4};

    always_comb begin
        round_d    = round_q;
        play_idx_d = play_idx_q;
        user_idx_d = user_idx_q;
        step_d     = step_q;
        tmo_d      = tmo_q;
        echo_d     = echo_q;
        err_d      = err_q;
        won_d      = won_q;
        end_fpga_d = end_fpga_q;
        end_user_d = end_user_q;
        end_time_d = end_time_q;
        mem_we     = 1'b0;
        mem_addr   = '0;
        exp_key    = onehot(mem_q[user_idx_q]);

        if (R1) begin
            round_d    = '0;
            play_idx_d = '0;
            user_idx_d = '0;
            step_d     = '0;
            tmo_d      = '0;
            echo_d     = '0;
            err_d      = 1'b0;
            won_d      = 1'b0;
            end_fpga_d = 1'b0;
            end_user_d = 1'b0;
            end_time_d = 1'b0;
        end else if (R2) begin
            play_idx_d = '0;
            user_idx_d = '0;
            step_d     = '0;
            tmo_d      = '0;
            echo_d     = '0;
            err_d      = 1'b0;
            end_fpga_d = 1'b0;
            end_user_d = 1'b0;
            end_time_d = 1'b0;
            if (round_q != LAST_ROUND) begin
                round_d  = round_q + 1'b1;
                mem_we   = 1'b1;
                mem_addr = round_q + 1'b1;
            end else begin
                won_d = 1'b1;
            end
        end else if (E3) begin
            if (step_q == STEP_LAST) begin
                step_d = '0;
                if (play_idx_q != round_q) play_idx_d = play_idx_q + 1'b1;
                else                       end_fpga_d = 1'b1;
            end else begin
                step_d = step_q + 1'b1;
            end
        end else if (E2) begin
            // A key always wins over a simultaneous timeout.
            if (KEY != 4'b0000) begin
                tmo_d = '0;
                if (!end_user_q) begin
                    echo_d = KEY;
                    if (KEY != exp_key) begin
                        err_d      = 1'b1;
                        end_user_d = 1'b1;
                    end else if (user_idx_q == round_q) begin
                        end_user_d = 1'b1;
                    end else begin
                        user_idx_d = user_idx_q + 1'b1;
                    end
                end
            end else if (tmo_q == TMO_LAST) begin
                end_time_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else if (E1) begin
            mem_we = 1'b1;
        end

        match_d = end_user_d & ~err_d;
    end

    always_ff @(posedge CLOCK) begin
        if (mem_we) mem_q[mem_addr] <= lfsr_q[1:0];
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            round_q    <= '0;
            play_idx_q <= '0;
            user_idx_q <= '0;
            step_q     <= '0;
            tmo_q      <= '0;
            echo_q     <= '0;
            err_q      <= 1'b0;
            won_q      <= 1'b0;
            match_q    <= 1'b0;
            end_fpga_q <= 1'b0;
            end_user_q <= 1'b0;
            end_time_q <= 1'b0;
        end else begin
            round_q    <= round_d;
            play_idx_q <= play_idx_d;
            user_idx_q <= user_idx_d;
            step_q     <= step_d;
            tmo_q      <= tmo_d;
            echo_q     <= echo_d;
            err_q      <= err_d;
            won_q      <= won_d;
            match_q    <= match_d;
            end_fpga_q <= end_fpga_d;
            end_user_q <= end_user_d;
            end_time_q <= end_time_d;
        end
    end

    always_comb begin
        LEDR = 4'b0000;
        if (reset) begin
            LEDR = 4'b0000;
        end else if (E3) begin
            if (step_q < STEP_HALF) LEDR = onehot(mem_q[play_idx_q]);
        end else if (E2) begin
            // The timeout counter restarts on each key, so it doubles as the echo timer.
            if (32'(tmo_q) < STEP_U) LEDR = echo_q;
        end else if (SEL) begin
            LEDR = won_q ? LED_WIN : LED_LOSE;
        end
    end

    assign ROUND    = round_q;
    assign end_FPGA = end_fpga_q;
    assign end_User = end_user_q;
    assign end_time = end_time_q;
    assign match    = match_q;
    assign win      = (round_q == LAST_ROUND) & ~err_q;

endmodule
